dump_instruc: RTL
=================

// Module: dump_instruc
// PURPOSE
//  Transmit-side counterpart of the UART instruction loader: reads NUM_WORDS 32-bit words
//  from a synchronous-read memory, starting at a byte base address.
//  Serialises each word MSB-first into 4 bytes for the UART transmitter, one byte per tx handshake.
//  Sits between the debug unit (which issues i_start) and uart_tx; used for memory/register dumps.
// PARAMETERS
//  NUM_WORDS   default 32  words sent per i_start (>=1)
//  ADDR_W      default 32  width of byte address o_rd_addr
// PORTS
//  i_clk          in   1       clock, all state updates on rising edge
//  i_reset        in   1       asynchronous, active-high reset
//  i_start        in   1       1-cycle request to begin a dump; honoured only in IDLE
//  i_base_addr    in   ADDR_W  byte address of first word, latched on accepted i_start
//  o_rd_addr      out  ADDR_W  byte address of word being fetched (increments by 4)
//  i_rd_data      in   32      memory read data, valid the cycle after o_rd_addr is stable
//  o_tx_data      out  8       byte for uart_tx, always = shift_reg[31:24]
//  o_tx_start     out  1       1-cycle pulse: uart_tx latches o_tx_data
//  i_tx_done      in   1       1-cycle pulse from uart_tx: byte fully sent
//  o_busy         out  1       high in every state except IDLE
//  o_done         out  1       1-cycle pulse after the last byte's i_tx_done
// BEHAVIOUR
//  Reset: state=IDLE; addr, shift_reg, byte_idx, word_cnt = 0; all outputs 0.
//  FSM states: IDLE, FETCH, CAPTURE, SEND, WAIT_TX, DONE.
//   IDLE:    i_start -> addr<=i_base_addr, word_cnt<=0, go FETCH. Else stay.
//   FETCH:   o_rd_addr=addr presented; unconditionally -> CAPTURE.
//   CAPTURE: shift_reg<=i_rd_data, byte_idx<=0 -> SEND.
//   SEND:    o_tx_start=1 for exactly this cycle -> WAIT_TX.
//   WAIT_TX: hold o_tx_data; on i_tx_done:
//            byte_idx<3  -> shift_reg<<=8, byte_idx++, -> SEND
//            byte_idx==3 & word_cnt<NUM_WORDS-1 -> addr<=addr+4, word_cnt++, -> FETCH
//            byte_idx==3 & word_cnt==NUM_WORDS-1 -> DONE
//   DONE:    o_done=1 for this cycle -> IDLE.
//  Latency: i_start in cycle T -> first o_tx_start in cycle T+3.
//   i_tx_done at t (mid-word) -> next o_tx_start at t+1.
//   i_tx_done at t (word end) -> next o_tx_start at t+3.
//   i_tx_done at t (last byte) -> o_done at t+1, o_busy low at t+2, new i_start accepted from t+2.
//  Byte order: byte0 = word[31:24] ... byte3 = word[7:0] (matches loader assembly).
//  Arithmetic: addr is ADDR_W bits and wraps modulo 2^ADDR_W; word_cnt width max(1,$clog2(NUM_WORDS)).
//  Ignored inputs:
//   i_start while o_busy=1 (including in DONE).
//   i_tx_done in any state other than WAIT_TX (so a done coincident with o_tx_start is dropped).
//   i_rd_data outside CAPTURE.
//  Reset mid-operation: immediate return to IDLE with reset values; a pending byte is abandoned.
//   No o_done is produced; the next dump restarts at byte0 of its new base.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE..DONE), BYTES_PER_WORD=4, ADDR_STEP=4.
//  The loader uses the same byte-order constants.
//  Single flat FSM + datapath (addr reg, 32-bit shift reg, 2-bit byte_idx, word_cnt).
//  No sub-module; uart_tx is instantiated by the parent, not here.
// TESTING
//  1 NUM_WORDS=1, base=0, mem[0]=32'hDEADBEEF, i_tx_done 10 cyc after each start
//    -> tx bytes DE,AD,BE,EF; 4 start pulses; o_done once; o_rd_addr=0.
//  2 NUM_WORDS=3, base=32'h10, mem={11223344,55667788,99AABBCC}
//    -> o_rd_addr 10,14,18; 12 bytes in order 11..CC; first start at T+3.
//  3 i_start pulsed while busy; i_tx_done pulsed in IDLE and in SEND cycle
//    -> byte stream and count unchanged, no extra o_tx_start.
//  4 Assert i_reset after 2nd byte's i_tx_done of word 0
//    -> all outputs 0 next edge; new i_start at base 0 resends byte DE first.
//  5 base=32'hFFFFFFFC, NUM_WORDS=2 -> second fetch at o_rd_addr=32'h00000000.
//  6 i_tx_done 1 cyc after each start; new i_start the cycle o_busy falls
//    -> exact t+1/t+3 spacing; second dump accepted without loss.

Source files
------------

// File: rtl/dump_instruc_pkg.sv
// Shared constants for the debug-unit memory dump path (FSM encoding and word/byte geometry).
// The instruction loader uses the same byte-order constants.
package dump_instruc_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

  // Index of the final byte in a word; bytes go out MSB-first, so this is word[7:0].
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  typedef struct packed {
    logic [2:0]  state;
    logic [1:0]  byte_idx;
  } dump_ctl_t;

endpackage

// File: rtl/dump_instruc_if.sv
// Dump engine bus: start/base from the debug unit, memory read port, and uart_tx byte handshake.
interface dump_instruc_if #(parameter int ADDR_W = 32);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [31:0]       i_rd_data;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              i_tx_done;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start, i_base_addr, i_rd_data, i_tx_done,
    output o_rd_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport master (
    output i_start, i_base_addr, i_rd_data, i_tx_done,
    input  o_rd_addr, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/dump_instruc.sv
// Reads NUM_WORDS words from a sync-read memory and streams each MSB-first, one byte per
// uart_tx handshake. Outputs are decoded straight from state so reset forces them all low.
module dump_instruc
  import dump_instruc_pkg::*;
#(
  parameter int NUM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  dump_instruc_if.slave  bus
);

  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WC_W-1:0]   LAST_WORD   = WC_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP_W = ADDR_W'(ADDR_STEP);

  dump_ctl_t         ctl;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       shift_reg;
  logic [WC_W-1:0]   word_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctl       <= '{state: S_IDLE, byte_idx: 2'd0};
      addr      <= '0;
      shift_reg <= '0;
      word_cnt  <= '0;
    end else begin
      case (ctl.state)
        S_IDLE: if (bus.i_start) begin
          addr      <= bus.i_base_addr;
          word_cnt  <= '0;
          ctl.state <= S_FETCH;
        end
        // Address has been stable since the previous edge; data shows up next cycle.
        S_FETCH:   ctl.state <= S_CAPTURE;
        S_CAPTURE: begin
          shift_reg    <= bus.i_rd_data;
          ctl.byte_idx <= 2'd0;
          ctl.state    <= S_SEND;
        end
        S_SEND:    ctl.state <= S_WAIT_TX;
        S_WAIT_TX: if (bus.i_tx_done) begin
          if (ctl.byte_idx != LAST_BYTE) begin
            shift_reg    <= {shift_reg[23:0], 8'h00};
            ctl.byte_idx <= ctl.byte_idx + 2'd1;
            ctl.state    <= S_SEND;
          end else if (word_cnt != LAST_WORD) begin
            addr      <= addr + ADDR_STEP_W;
            word_cnt  <= word_cnt + WC_W'(1);
            ctl.state <= S_FETCH;
          end else begin
            ctl.state <= S_DONE;
          end
        end
        S_DONE:    ctl.state <= S_IDLE;
        default:   ctl.state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_rd_addr  = addr;
  assign bus.o_tx_data  = shift_reg[31:24];
  assign bus.o_tx_start = (ctl.state == S_SEND);
  assign bus.o_busy     = (ctl.state != S_IDLE);
  assign bus.o_done     = (ctl.state == S_DONE);

endmodule
